// File: rtl/safe_pkg.sv
// Shared types for the safe 2-bit state-code link: code constants, encoder
// state encoding, decoder FSM states and transition classes.
package safe_pkg;

  localparam logic [1:0] CODE_S0 = 2'b01;
  localparam logic [1:0] CODE_S1 = 2'b10;
  localparam logic [1:0] CODE_S2 = 2'b11;
  localparam logic [1:0] CODE_S3 = 2'b00;

  // Enum values are the wire codes, so a cast from code_in is lossless.
  typedef enum logic [1:0] {
    S0 = 2'b01,
    S1 = 2'b10,
    S2 = 2'b11,
    S3 = 2'b00
  } safe_state_t;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } dec_state_t;

  typedef enum logic [2:0] {
    NOBIT   = 3'd0,
    BIT0    = 3'd1,
    BIT1    = 3'd2,
    RESYNC  = 3'd3,
    ILLEGAL = 3'd4
  } trans_t;

  function automatic safe_state_t code_to_state(input logic [1:0] code);
    return safe_state_t'(code);
  endfunction

endpackage

// File: rtl/safe_trans_class.sv
// Combinational classifier: maps a (previous, current) encoder state pair to
// the kind of transition it represents on the link.
module safe_trans_class
  import safe_pkg::*;
(
  input  safe_state_t prev_i,
  input  safe_state_t cur_i,
  output trans_t      trans_o
);

  // Pair lookup; anything not explicitly legal is treated as illegal.
  always_comb begin
    trans_o = ILLEGAL;
    case (prev_i)
      S0: begin
        case (cur_i)
          S0, S1:  trans_o = NOBIT;
          default: trans_o = ILLEGAL;
        endcase
      end
      S1: begin
        case (cur_i)
          S1:      trans_o = BIT0;
          S2:      trans_o = BIT1;
          S0:      trans_o = RESYNC;
          default: trans_o = ILLEGAL;
        endcase
      end
      S2: begin
        case (cur_i)
          S1:      trans_o = BIT0;
          S3:      trans_o = BIT1;
          S0:      trans_o = RESYNC;
          default: trans_o = ILLEGAL;
        endcase
      end
      S3: begin
        case (cur_i)
          S3:      trans_o = BIT0;
          S2:      trans_o = BIT1;
          S0:      trans_o = RESYNC;
          default: trans_o = ILLEGAL;
        endcase
      end
      default: trans_o = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/safe_stream_decoder.sv
// Receive-side decoder for the safe 4-state code link: locks onto S0, recovers
// data bits from state transitions, packs them MSB-first and counts illegal pairs.
module safe_stream_decoder
  import safe_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        code_in,
  output logic              locked,
  output logic [1:0]        state_out,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              err,
  output logic [ERR_W-1:0]  err_count
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  dec_state_t        state_q, state_d;
  safe_state_t       prev_q, prev_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              locked_q, locked_d;
  logic [1:0]        state_out_q, state_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              bit_out_q, bit_out_d;
  logic              word_valid_q, word_valid_d;
  logic              err_q, err_d;

  safe_state_t       cur_s;
  trans_t            trans_s;
  logic              new_bit_s;

  assign cur_s     = code_to_state(code_in);
  assign new_bit_s = (trans_s == BIT1);

  safe_trans_class u_trans_class (
    .prev_i  (prev_q),
    .cur_i   (cur_s),
    .trans_o (trans_s)
  );

  // Next-state logic for the lock FSM, word assembly and error tracking.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    word_d       = word_q;
    err_cnt_d    = err_cnt_q;
    locked_d     = locked_q;
    bit_valid_d  = 1'b0;
    bit_out_d    = 1'b0;
    word_valid_d = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      HUNT: begin
        if (code_in == CODE_S0) begin
          state_d  = TRACK;
          prev_d   = S0;
          locked_d = 1'b1;
        end else begin
          locked_d = 1'b0;
        end
      end
      TRACK: begin
        prev_d   = cur_s;
        locked_d = 1'b1;
        case (trans_s)
          BIT0, BIT1: begin
            bit_valid_d = 1'b1;
            bit_out_d   = new_bit_s;
            shreg_d     = {shreg_q[WORD_W-2:0], new_bit_s};
            if (bit_cnt_q == CNT_LAST) begin
              word_d       = shreg_d;
              word_valid_d = 1'b1;
              bit_cnt_d    = {CNT_W{1'b0}};
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          RESYNC: begin
            bit_cnt_d = {CNT_W{1'b0}};
            shreg_d   = {WORD_W{1'b0}};
          end
          ILLEGAL: begin
            err_d     = 1'b1;
            state_d   = HUNT;
            locked_d  = 1'b0;
            bit_cnt_d = {CNT_W{1'b0}};
            shreg_d   = {WORD_W{1'b0}};
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end
          default: begin
            bit_cnt_d = bit_cnt_q;
          end
        endcase
      end
      default: begin
        state_d  = HUNT;
        locked_d = 1'b0;
      end
    endcase

    state_out_d = locked_d ? code_in : CODE_S0;
  end

  // State and output registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= HUNT;
      prev_q       <= S0;
      bit_cnt_q    <= {CNT_W{1'b0}};
      shreg_q      <= {WORD_W{1'b0}};
      word_q       <= {WORD_W{1'b0}};
      err_cnt_q    <= {ERR_W{1'b0}};
      locked_q     <= 1'b0;
      state_out_q  <= CODE_S0;
      bit_valid_q  <= 1'b0;
      bit_out_q    <= 1'b0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      word_q       <= word_d;
      err_cnt_q    <= err_cnt_d;
      locked_q     <= locked_d;
      state_out_q  <= state_out_d;
      bit_valid_q  <= bit_valid_d;
      bit_out_q    <= bit_out_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
    end
  end

  assign locked     = locked_q;
  assign state_out  = state_out_q;
  assign bit_valid  = bit_valid_q;
  assign bit_out    = bit_out_q;
  assign word_valid = word_valid_q;
  assign word_out   = word_q;
  assign err        = err_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_safe_stream_decoder.sv
// Directed bench for safe_stream_decoder: reset, bit recovery, word packing,
// illegal pairs, resync, reset mid-word and error-counter saturation.
module tb_safe_stream_decoder;

  logic       clk;
  logic       reset;
  logic [1:0] code_in;
  logic       locked;
  logic [1:0] state_out;
  logic       bit_valid;
  logic       bit_out;
  logic       word_valid;
  logic [7:0] word_out;
  logic       err;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] enc;

  safe_stream_decoder #(.WORD_W(8), .ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .locked     (locked),
    .state_out  (state_out),
    .bit_valid  (bit_valid),
    .bit_out    (bit_out),
    .word_valid (word_valid),
    .word_out   (word_out),
    .err        (err),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Golden encoder: next wire code given current code and data bit.
  function automatic logic [1:0] enc_next(input logic [1:0] cur, input logic d);
    case (cur)
      2'b01:   return 2'b10;
      2'b10:   return d ? 2'b11 : 2'b10;
      2'b11:   return d ? 2'b00 : 2'b10;
      2'b00:   return d ? 2'b11 : 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  task automatic step(input logic [1:0] c);
    @(negedge clk);
    code_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_locked"},     32'(locked),     32'd0);
    check({pfx, "_state_out"},  32'(state_out),  32'h1);
    check({pfx, "_bit_valid"},  32'(bit_valid),  32'd0);
    check({pfx, "_bit_out"},    32'(bit_out),    32'd0);
    check({pfx, "_word_valid"}, 32'(word_valid), 32'd0);
    check({pfx, "_word_out"},   32'(word_out),   32'd0);
    check({pfx, "_err"},        32'(err),        32'd0);
    check({pfx, "_err_count"},  32'(err_count),  32'd0);
  endtask

  task automatic lock_and_sync();
    step(2'b01);
    check("sync_locked", 32'(locked), 32'd1);
    step(2'b10);
    check("sync_nobit", 32'(bit_valid), 32'd0);
    enc = 2'b10;
  endtask

  task automatic send_bit(input logic d, input logic wv);
    enc = enc_next(enc, d);
    step(enc);
    check("bit_valid",  32'(bit_valid),  32'd1);
    check("bit_out",    32'(bit_out),    32'(d));
    check("word_valid", 32'(word_valid), 32'(wv));
    check("bit_err",    32'(err),        32'd0);
    check("state_out",  32'(state_out),  32'(enc));
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], (i == 0));
    end
    check("word_out", 32'(word_out), 32'(w));
  endtask

  logic [1:0] rec_codes [7] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10, 2'b10};
  logic       rec_bv    [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       rec_bo    [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    reset   = 1'b0;
    code_in = 2'b00;
    enc     = 2'b01;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      code_in = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      check_idle("reset");
    end
    reset = 1'b1;

    // HUNT ignores a non-S0 code without raising err
    step(2'b11);
    check("hunt_locked", 32'(locked), 32'd0);
    check("hunt_err",    32'(err),    32'd0);

    for (int i = 0; i < 7; i++) begin
      step(rec_codes[i]);
      check("rec_locked",    32'(locked),    32'd1);
      check("rec_bit_valid", 32'(bit_valid), 32'(rec_bv[i]));
      check("rec_bit_out",   32'(bit_out),   32'(rec_bo[i]));
      check("rec_err",       32'(err),       32'd0);
      check("rec_state_out", 32'(state_out), 32'(rec_codes[i]));
    end

    // Resync after 5 bits: partial word dropped, stays locked
    step(2'b01);
    check("resync_err",    32'(err),        32'd0);
    check("resync_locked", 32'(locked),     32'd1);
    check("resync_bv",     32'(bit_valid),  32'd0);
    check("resync_wv",     32'(word_valid), 32'd0);
    enc = 2'b01;
    step(2'b10);
    enc = 2'b10;
    send_word(8'hA5);
    send_word(8'hFF);

    // Illegal S1->S3 after partial word
    lock_and_sync();
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b0, 1'b0);
    end
    step(2'b00);
    check("ill_err",       32'(err),        32'd1);
    check("ill_err_count", 32'(err_count),  32'd1);
    check("ill_locked",    32'(locked),     32'd0);
    check("ill_wv",        32'(word_valid), 32'd0);
    check("ill_bv",        32'(bit_valid),  32'd0);
    check("ill_state_out", 32'(state_out),  32'h1);
    check("ill_word_hold", 32'(word_out),   32'hFF);
    step(2'b00);
    check("ign1_err",    32'(err),       32'd0);
    check("ign1_locked", 32'(locked),    32'd0);
    step(2'b11);
    check("ign2_err",       32'(err),       32'd0);
    check("ign2_locked",    32'(locked),    32'd0);
    check("ign2_err_count", 32'(err_count), 32'd1);
    lock_and_sync();
    send_word(8'h3C);

    // Reset mid-word
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    reset   = 1'b0;
    code_in = enc_next(enc, 1'b1);
    @(posedge clk);
    #1;
    check_idle("rst_mid");
    reset = 1'b1;
    lock_and_sync();
    send_word(8'h81);

    // Error counter saturation
    for (int i = 1; i <= 300; i++) begin
      step(2'b01);
      step(2'b11);
      if (i == 1) begin
        check("sat_first", 32'(err_count), 32'd1);
      end else if (i == 254) begin
        check("sat_254", 32'(err_count), 32'd254);
      end else if (i == 255) begin
        check("sat_255", 32'(err_count), 32'd255);
      end else begin
        n_checks = n_checks;
      end
    end
    check("sat_final",     32'(err_count), 32'd255);
    check("sat_err_pulse", 32'(err),       32'd1);
    check("sat_locked",    32'(locked),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/safe_stream_decoder.md
# safe_stream_decoder

Receive-side companion to the team's safe 4-state encoder FSM. It samples the encoder's 2-bit state code every clock, reconstructs the `data_in` bit that caused each transition, and flags illegal transitions. It also packs recovered bits MSB-first into `WORD_W`-bit words. It sits on the far end of the 2-bit code link, either on the monitoring side or the consuming side.

## Interface
Parameters:
- `WORD_W`, default 8: bits per assembled word, minimum 2.
- `ERR_W`, default 8: width of the saturating error counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-low.
- `code_in`, in, 2: encoder state code, one per clock. Mapping is 01=S0, 10=S1, 11=S2, 00=S3.
- `locked`, out, 1: decoder is in TRACK.
- `state_out`, out, 2: last sampled code while locked. Otherwise 01.
- `bit_valid`, out, 1: one-cycle pulse when a bit is recovered.
- `bit_out`, out, 1: recovered bit, qualified by `bit_valid`.
- `word_valid`, out, 1: one-cycle pulse when a word is complete.
- `word_out`, out, WORD_W: assembled word. Holds its value until the next `word_valid`.
- `err`, out, 1: one-cycle pulse on an illegal transition.
- `err_count`, out, ERR_W: saturating count of `err` pulses.

## Operation
- **Decoder FSM:** two states, HUNT and TRACK.
- **HUNT:**
  - On `code_in`=01, go to TRACK with prev=S0.
  - Any other code is ignored. It produces no `err`.
- **TRACK:** classify each (prev, cur) pair, then set prev to cur.
  - S0→S1: sync marker, no bit.
  - S0→S0: encoder held in reset. No bit, no error.
  - S1→S1: bit 0. S1→S2: bit 1.
  - S2→S1: bit 0. S2→S3: bit 1.
  - S3→S3: bit 0. S3→S2: bit 1.
  - Any state→S0 (except from S0): resync. No bit, no error. Partial word cleared, `bit_cnt` reset to 0, stay in TRACK.
  - S0→S2, S0→S3, S1→S3, S2→S2, S3→S1: illegal. Pulse `err`, increment `err_count` (saturating at all-ones), clear the partial word and `bit_cnt`, go to HUNT.
- **Word assembly:**
  - Each recovered bit shifts in: `shreg <= {shreg[WORD_W-2:0], bit}`.
  - When `bit_cnt` reaches WORD_W-1 and a bit arrives: `word_out` gets the completed value, `word_valid` pulses, and `bit_cnt` wraps to 0.
- **Reset** (`reset`=0 at a clock edge):
  - FSM goes to HUNT. `bit_cnt` and `shreg` go to 0.
  - `locked`, `bit_valid`, `bit_out`, `word_valid`, `err` all 0.
  - `word_out` and `err_count` go to 0. `state_out` goes to 01.
  - Reset mid-word discards the partial word silently, with no `err`.

## Timing
- **Latency:** a transition whose second code is sampled at edge k produces `bit_valid`/`bit_out`/`err` registered at edge k. They are visible for exactly one cycle, from edge k to edge k+1.
- **Word completion:** `word_valid` and `word_out` update on the same edge as the final `bit_valid` of the word.
- **`locked`:** rises on the edge that samples the first 01 in HUNT. Falls on the edge that detects an illegal pair.
- **Throughput:** at most one bit per clock. No back-pressure; the consumer must accept every pulse.
- **Reset priority:** reset overrides all other events on the same edge.

## Structure
- **Package `safe_pkg`:**
  - Code constants `CODE_S0..CODE_S3`.
  - Encoder state enum `safe_state_t` with values S0..S3.
  - Decoder state enum `dec_state_t` with values HUNT and TRACK.
  - Transition class enum `trans_t`: NOBIT, BIT0, BIT1, RESYNC, ILLEGAL.
- **Sub-module `safe_trans_class`:** purely combinational. Maps (prev, cur) to `trans_t`. The top level holds the FSM, shift register, counters and output registers.

## Test plan
- **Reset:** hold `reset`=0 for 2 clocks with random `code_in` → all outputs 0, `state_out`=01, `locked`=0.
- **Bit recovery:** codes 01,10,11,00,11,10,10 → `locked` rises on the first 01; bits 1,1,1,0,0 on consecutive cycles; no `err`.
- **Word assembly** (WORD_W=8): a golden encoder model driven with `data_in` sequence 1,0,1,0,0,1,0,1 after sync → `word_out`=0xA5 with one `word_valid` on the 8th bit. A second word 0xFF follows back-to-back with no gap.
- **Illegal transition:** after 3 bits, drive 10 then 00 (S1→S3) → `err` pulse, `err_count`=1, `locked`=0, no `word_valid`. Following codes 00,11 are ignored. Relock on 01.
- **Resync mid-word:** after 5 bits drive 01 → no `err`, `locked` stays 1, partial word discarded. The next 8 bits form a fresh word.
- **Reset mid-word and saturation:** reset after 4 bits → no `word_valid`, no `err`. Separately, 300 illegal events → `err_count` holds at 255.
